// File: rtl/rv_pkg.sv
// Shared RV32I datapath types used by the comparer (optional equal_o via RV_COMPARER_EQ_EN).
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

endpackage

// File: rtl/rv_comparer_slice4.sv
// 4-bit unsigned magnitude slice: leaf of the comparer lt/eq tree.
module cmp_slice4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       lt_o,
  output logic       eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/rv_comparer.sv
// Registered A<B comparer (signed/unsigned) built from a 4-bit slice tree.
// Define RV_COMPARER_EQ_EN to add the registered equal_o output.
module rv_comparer
  import rv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             signedFlag_i,
`ifdef RV_COMPARER_EQ_EN
  output logic             equal_o,
`endif
  output logic             less_o
);

  localparam int NS = WIDTH / 4;
  localparam int LG = (NS > 1) ? $clog2(NS) : 0;
  localparam int NP = 1 << LG;
  localparam int NN = 2 * NP - 1;

  cmp_mode_e        mode;
  logic [NS-1:0]    s_lt;
  logic [NS-1:0]    s_eq;
  logic [NN-1:0]    n_lt;
  logic [NN-1:0]    n_eq;
  logic             a_msb;
  logic             b_msb;
  logic             less_d;
  logic             less_q;

  assign mode = cmp_mode_e'(signedFlag_i);

  for (genvar i = 0; i < NS; i++) begin : g_slice
    cmp_slice4 u_slice (
      .a_i  (A_i[4*i +: 4]),
      .b_i  (B_i[4*i +: 4]),
      .lt_o (s_lt[i]),
      .eq_o (s_eq[i])
    );
  end

  // Leaves are MSB-first; padding sits at the low end as neutral (eq=1).
  for (genvar j = 0; j < NP; j++) begin : g_leaf
    if (j < NS) begin : g_real
      assign n_lt[NP-1+j] = s_lt[NS-1-j];
      assign n_eq[NP-1+j] = s_eq[NS-1-j];
    end else begin : g_pad
      assign n_lt[NP-1+j] = 1'b0;
      assign n_eq[NP-1+j] = 1'b1;
    end
  end

  for (genvar k = 0; k < NP - 1; k++) begin : g_node
    assign n_lt[k] = n_lt[2*k+1]
                   | (n_eq[2*k+1] & n_lt[2*k+2]);
    assign n_eq[k] = n_eq[2*k+1] & n_eq[2*k+2];
  end

  assign a_msb = A_i[WIDTH-1];
  assign b_msb = B_i[WIDTH-1];

  always_comb begin
    less_d = n_lt[0];
    if (mode == CMP_SIGNED && (a_msb ^ b_msb))
      less_d = a_msb;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) less_q <= 1'b0;
    else            less_q <= less_d;
  end

  assign less_o = less_q;

`ifdef RV_COMPARER_EQ_EN
  logic equal_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) equal_q <= 1'b0;
    else            equal_q <= n_eq[0];
  end

  assign equal_o = equal_q;
`endif

endmodule

// File: tb/tb_rv_comparer.sv
// Directed-vector bench for rv_comparer (equal_o checked when RV_COMPARER_EQ_EN).
module tb_rv_comparer;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        less;
  logic        equal;
  int          n_chk;
  int          n_err;

  rv_comparer #(.WIDTH(32)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .A_i          (a),
    .B_i          (b),
    .signedFlag_i (sgn),
`ifdef RV_COMPARER_EQ_EN
    .equal_o      (equal),
`endif
    .less_o       (less)
  );

`ifndef RV_COMPARER_EQ_EN
  assign equal = 1'b0;
`endif

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] va,
                     input logic [31:0] vb, input logic vs,
                     input logic exp_lt);
    a   = va;
    b   = vb;
    sgn = vs;
    @(posedge clk);
    @(negedge clk);
    chk(tag, less, exp_lt);
`ifdef RV_COMPARER_EQ_EN
    chk({tag, "_eq"}, equal, (va == vb) && rst_n);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    a     = 32'd1;
    b     = 32'd2;
    sgn   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_hold", less, 1'b0);
`ifdef RV_COMPARER_EQ_EN
      chk("rst_hold_eq", equal, 1'b0);
`endif
    end
    #20;
    rst_n = 1'b1;

    vec("first",   32'd1,        32'd2,        1'b0, 1'b1);
    vec("u_gt",    32'd12345,    32'd12344,    1'b0, 1'b0);
    vec("u_lt",    32'd56565,    32'd65656,    1'b0, 1'b1);
    vec("u_eq",    32'd11111,    32'd11111,    1'b0, 1'b0);
    vec("s_eq",    32'd11111,    32'd11111,    1'b1, 1'b0);
    vec("u_big",   32'd87654321, 32'd87655321, 1'b0, 1'b1);
    vec("mix_s",   32'h80012345, 32'h00012345, 1'b1, 1'b1);
    vec("mix_u",   32'h80012345, 32'h00012345, 1'b0, 1'b0);
    vec("neg_u",   32'hFFFF1234, 32'hFFFF1233, 1'b0, 1'b0);
    vec("neg_s",   32'hFFFF1234, 32'hFFFF1233, 1'b1, 1'b0);
    vec("neg_sw",  32'hFFFF1233, 32'hFFFF1234, 1'b1, 1'b1);
    vec("min_s",   32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    vec("min_u",   32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
    vec("zero_u",  32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    vec("zero_s",  32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    vec("max_u",   32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    vec("min_eq",  32'h80000000, 32'h80000000, 1'b1, 1'b0);
    vec("slc_gt",  32'h00000010, 32'h0000000F, 1'b0, 1'b0);
    vec("slc_lt",  32'h0000000F, 32'h00000010, 1'b0, 1'b1);
    vec("low_lt",  32'h12345670, 32'h12345671, 1'b0, 1'b1);
    vec("mid_gt",  32'h12395670, 32'h12345671, 1'b1, 1'b0);

    rst_n = 1'b0;
    vec("mid_rst", 32'd1,        32'd2,        1'b0, 1'b0);
    rst_n = 1'b1;
    vec("resume",  32'd1,        32'd2,        1'b0, 1'b1);
    vec("res_eq",  32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b0);
    vec("res_neg", 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
